// File: rtl/seg_pkg.sv
// ----------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the seven-segment scan controller: decoder code
// points understood by the seven_seg decoder and the scan FSM state type.
// ----------------------------------------------------------------------------
package seg_pkg;

   // Decoder code points above the decimal digits.
   localparam logic [3:0] SEG_BLANK = 4'd10;
   localparam logic [3:0] SEG_N     = 4'd11;
   localparam logic [3:0] SEG_E     = 4'd12;
   localparam logic [3:0] SEG_P     = 4'd13;
   localparam logic [3:0] SEG_O     = 4'd14;

   // BLANK: inter-digit gap with all digits off; SHOW: one digit driven.
   typedef enum logic {
      BLANK,
      SHOW
   } state_e;

endpackage : seg_pkg

// File: rtl/seg_lz_mask.sv
// ----------------------------------------------------------------------------
// seg_lz_mask
// Combinational leading-zero suppression. Starting from the most significant
// position, every position whose code and all higher codes are 0 is replaced
// by the blank code. Position 0 always passes through so a value of zero
// still shows a single "0". Any non-zero code (including 10-15) ends the run.
//
// Ports:
//   en_i     - enable suppression; when low the codes pass through untouched
//   codes_i  - DIGITS packed 4-bit codes, position 0 in bits [3:0]
//   codes_o  - codes after suppression, same packing
// ----------------------------------------------------------------------------
module seg_lz_mask
   import seg_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic                en_i,
   input  logic [4*DIGITS-1:0] codes_i,
   output logic [4*DIGITS-1:0] codes_o
);

   logic zero_run;

   // NOTE: combinational logic uses blocking '=' and assigns every output a
   // default first, so no path leaves a value held and no latch is inferred.
   always_comb begin
      codes_o  = codes_i;
      zero_run = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         zero_run = zero_run & (codes_i[4*i +: 4] == 4'd0);
         if (en_i && zero_run) begin
            codes_o[4*i +: 4] = SEG_BLANK;
         end
      end
   end

endmodule : seg_lz_mask

// File: rtl/seg_scan_ctrl.sv
// ----------------------------------------------------------------------------
// seg_scan_ctrl
// Time-multiplexed scan controller for a common-anode seven-segment display.
// Sequences one shared seven_seg decoder across DIGITS positions: a BLANK gap
// of BLANK_CYC clocks, then DWELL clocks of SHOW for each position in order
// 0..DIGITS-1. Codes are written into a shadow buffer and copied into the
// active buffer only on the last SHOW cycle of the last position, so a frame
// never mixes old and new data.
//
// Ports:
//   clk        - system clock, all logic on the rising edge
//   rst        - synchronous active-high reset
//   load       - one-cycle strobe, captures load_data into the shadow buffer
//   load_data  - DIGITS packed 4-bit codes, position 0 in bits [3:0]
//   lz_blank   - leading-zero suppression enable
//   pending    - shadow buffer holds data not yet committed
//   seg_number - code for the external seven_seg decoder
//   dig_sel    - active-low digit enables, at most one bit low
//   frame_tick - one-cycle pulse on the commit cycle
// ----------------------------------------------------------------------------
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int DIGITS    = 4,
   parameter int DWELL     = 50000,
   parameter int BLANK_CYC = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic [4*DIGITS-1:0] load_data,
   input  logic                lz_blank,
   output logic                pending,
   output logic [3:0]          seg_number,
   output logic [DIGITS-1:0]   dig_sel,
   output logic                frame_tick
);

   localparam int CNT_MAX = (DWELL > BLANK_CYC) ? DWELL : BLANK_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX);
   localparam int IDX_W   = $clog2(DIGITS);

   localparam logic [CNT_W-1:0]    DWELL_LAST = CNT_W'(DWELL - 1);
   localparam logic [CNT_W-1:0]    BLANK_LAST = CNT_W'(BLANK_CYC - 1);
   localparam logic [IDX_W-1:0]    IDX_LAST   = IDX_W'(DIGITS - 1);
   localparam logic [4*DIGITS-1:0] ALL_BLANK  = {DIGITS{SEG_BLANK}};

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [4*DIGITS-1:0] active_q, active_d;
   logic [4*DIGITS-1:0] shadow_q, shadow_d;
   logic                pending_q, pending_d;
   logic [3:0]          seg_q, seg_d;
   logic [DIGITS-1:0]   dig_sel_q, dig_sel_d;
   logic                tick_q, tick_d;

   logic                commit;
   logic [4*DIGITS-1:0] shown_codes;

   seg_lz_mask #(
      .DIGITS (DIGITS)
   ) u_lz_mask (
      .en_i    (lz_blank),
      .codes_i (active_q),
      .codes_o (shown_codes)
   );

   // Last SHOW cycle of the last position closes the frame.
   assign commit = (state_q == SHOW) && (cnt_q == DWELL_LAST) && (idx_q == IDX_LAST);

   // Scan sequencing: dwell counter, state and position index.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      idx_d   = idx_q;
      case (state_q)
         BLANK: begin
            if (cnt_q == BLANK_LAST) begin
               state_d = SHOW;
               cnt_d   = '0;
            end
         end
         SHOW: begin
            if (cnt_q == DWELL_LAST) begin
               state_d = BLANK;
               cnt_d   = '0;
               idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end
         end
         default: begin
            state_d = BLANK;
            cnt_d   = '0;
         end
      endcase
   end

   // Shadow/active buffers. A load on the commit cycle still lets the commit
   // take the previous shadow value, and the fresh load keeps pending set.
   always_comb begin
      active_d  = active_q;
      shadow_d  = shadow_q;
      pending_d = pending_q;
      if (commit && pending_q) begin
         active_d  = shadow_q;
         pending_d = 1'b0;
      end
      if (load) begin
         shadow_d  = load_data;
         pending_d = 1'b1;
      end
   end

   // Registered outputs describe the state/count that will be current after
   // the edge. The code is latched on SHOW entry and held for the dwell, so
   // lz_blank changes only show up at the next digit. The enable waits one
   // cycle into SHOW to match the decoder's registered latency.
   always_comb begin
      seg_d     = seg_q;
      dig_sel_d = '1;
      tick_d    = (state_d == SHOW) && (cnt_d == DWELL_LAST) && (idx_d == IDX_LAST);
      if (state_d == BLANK) begin
         seg_d = SEG_BLANK;
      end else if (state_q == BLANK) begin
         seg_d = shown_codes[{idx_d, 2'b00} +: 4];
      end
      if ((state_d == SHOW) && (cnt_d != '0)) begin
         dig_sel_d[idx_d] = 1'b0;
      end
   end

   // NOTE: sequential state is updated with non-blocking '<=' so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= BLANK;
         cnt_q     <= '0;
         idx_q     <= '0;
         active_q  <= ALL_BLANK;
         shadow_q  <= ALL_BLANK;
         pending_q <= 1'b0;
         seg_q     <= SEG_BLANK;
         dig_sel_q <= '1;
         tick_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         active_q  <= active_d;
         shadow_q  <= shadow_d;
         pending_q <= pending_d;
         seg_q     <= seg_d;
         dig_sel_q <= dig_sel_d;
         tick_q    <= tick_d;
      end
   end

   assign pending    = pending_q;
   assign seg_number = seg_q;
   assign dig_sel    = dig_sel_q;
   assign frame_tick = tick_q;

endmodule : seg_scan_ctrl

// File: tb/tb_seg_scan_ctrl.sv
// ----------------------------------------------------------------------------
// tb_seg_scan_ctrl
// Directed bench for seg_scan_ctrl with DIGITS=4, DWELL=4, BLANK_CYC=2
// (24-cycle frame). Within a frame, phase p*6+c is position p at step c:
// c=0,1 BLANK, c=2 SHOW count 0 (code out, enable off), c=3..5 enable low.
// ----------------------------------------------------------------------------
module tb_seg_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        load;
   logic [15:0] load_data;
   logic        lz_blank;
   logic        pending;
   logic [3:0]  seg_number;
   logic [3:0]  dig_sel;
   logic        frame_tick;

   int total = 0;
   int bad   = 0;

   seg_scan_ctrl #(
      .DIGITS    (4),
      .DWELL     (4),
      .BLANK_CYC (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .load_data  (load_data),
      .lz_blank   (lz_blank),
      .pending    (pending),
      .seg_number (seg_number),
      .dig_sel    (dig_sel),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   // Advance one clock; outputs are then sampled 1 time unit after the edge.
   task automatic clk1();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp_v);
      end
   endtask

   // Walk one frame from its BLANK-of-position-0 cycle, checking every cycle.
   // Optional loads are driven during phases pa and pb; pend_end is the
   // expected pending flag on the commit cycle (phase 23).
   task automatic check_frame(input string tag, input logic [15:0] codes,
                              input int pa, input logic [15:0] da,
                              input int pb, input logic [15:0] db,
                              input logic pend_end);
      int         p;
      int         c;
      logic [3:0] es;
      logic [3:0] ed;
      logic       et;
      for (int ph = 0; ph < 24; ph++) begin
         p  = ph / 6;
         c  = ph % 6;
         es = (c < 2) ? 4'd10 : codes[4*p +: 4];
         ed = (c < 3) ? 4'b1111 : ~(4'b0001 << p);
         et = (ph == 23);
         chk($sformatf("%s ph%0d seg/dig/tick", tag, ph),
             {23'd0, seg_number, dig_sel, frame_tick}, {23'd0, es, ed, et});
         if (ph == 23) begin
            chk($sformatf("%s pending@commit", tag), {31'd0, pending}, {31'd0, pend_end});
         end
         if (ph == pa) begin
            load      = 1'b1;
            load_data = da;
         end else if (ph == pb) begin
            load      = 1'b1;
            load_data = db;
         end
         clk1();
         load = 1'b0;
      end
   endtask

   initial begin
      int         ph;
      int         p;
      int         c;
      logic [3:0] ed;

      rst       = 1'b1;
      load      = 1'b0;
      load_data = 16'h0000;
      lz_blank  = 1'b0;

      // Reset held three cycles.
      clk1();
      clk1();
      clk1();
      chk("reset seg",     {28'd0, seg_number}, 32'd10);
      chk("reset dig",     {28'd0, dig_sel},    32'hF);
      chk("reset tick",    {31'd0, frame_tick}, 32'd0);
      chk("reset pending", {31'd0, pending},    32'd0);
      rst = 1'b0;

      // First frame after reset shows the all-blank active buffer; a load of
      // 1234 lands mid-frame and stays pending until the commit.
      check_frame("f0", 16'hAAAA, 5, 16'h1234, -1, 16'h0, 1'b1);
      chk("f0 pending after commit", {31'd0, pending}, 32'd0);
      check_frame("f1", 16'h1234, -1, 16'h0, -1, 16'h0, 1'b0);

      // ABCD mid-frame, then 5678 exactly on the commit cycle.
      check_frame("f2", 16'h1234, 8, 16'hABCD, 23, 16'h5678, 1'b1);
      chk("f2 pending after coincident load", {31'd0, pending}, 32'd1);
      check_frame("f3", 16'hABCD, -1, 16'h0, -1, 16'h0, 1'b1);
      chk("f3 pending after second commit", {31'd0, pending}, 32'd0);

      // Leading-zero blanking.
      check_frame("f4", 16'h5678, 3, 16'h0070, -1, 16'h0, 1'b1);
      lz_blank = 1'b1;
      check_frame("f5 lz 0070", 16'hAA70, -1, 16'h0, -1, 16'h0, 1'b0);
      lz_blank = 1'b0;
      check_frame("f6 nolz 0070", 16'h0070, 10, 16'h0000, -1, 16'h0, 1'b1);
      lz_blank = 1'b1;
      check_frame("f7 lz 0000", 16'hAAA0, 2, 16'h0B00, -1, 16'h0, 1'b1);
      check_frame("f8 lz 0B00", 16'hAB00, -1, 16'h0, -1, 16'h0, 1'b0);

      // Mid-frame reset during SHOW of position 2 with a load pending.
      for (int k = 0; k < 15; k++) begin
         if (k == 3) begin
            load      = 1'b1;
            load_data = 16'h9999;
         end
         clk1();
         load = 1'b0;
      end
      chk("pre-rst dig",     {28'd0, dig_sel},    32'hB);
      chk("pre-rst seg",     {28'd0, seg_number}, 32'hB);
      chk("pre-rst pending", {31'd0, pending},    32'd1);
      rst       = 1'b1;
      load      = 1'b1;
      load_data = 16'h4444;
      clk1();
      rst  = 1'b0;
      load = 1'b0;
      chk("mid-rst seg",     {28'd0, seg_number}, 32'd10);
      chk("mid-rst dig",     {28'd0, dig_sel},    32'hF);
      chk("mid-rst tick",    {31'd0, frame_tick}, 32'd0);
      chk("mid-rst pending", {31'd0, pending},    32'd0);
      // Active buffer must be all blank and the load beside reset discarded.
      check_frame("post-rst", 16'hAAAA, -1, 16'h0, -1, 16'h0, 1'b0);

      // Random loads: enable exclusivity and timing, plus frame_tick cadence.
      for (int k = 0; k < 10000; k++) begin
         ph = k % 24;
         p  = ph / 6;
         c  = ph % 6;
         ed = (c < 3) ? 4'b1111 : ~(4'b0001 << p);
         chk($sformatf("rand k%0d dig/tick", k), {27'd0, dig_sel, frame_tick},
             {27'd0, ed, (ph == 23)});
         load      = ($urandom_range(0, 7) == 0);
         load_data = 16'($urandom);
         if ($urandom_range(0, 31) == 0) begin
            lz_blank = ~lz_blank;
         end
         clk1();
         load = 1'b0;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_seg_scan_ctrl
